// File: rtl/block_reconstructor_if.sv
// Stream bundle for the inverse 5/3 row decoder: coefficient pairs in, pixels out.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the coefficient side, out_valid/out_ready on the pixel side.
interface block_reconstructor_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] s_in;
   logic [7:0] d_in;
   logic [7:0] x_out;
   logic       out_valid;
   logic       out_ready;

   // Producer of coefficients and consumer of pixels.
   modport master (
      output in_valid, s_in, d_in, out_ready,
      input  in_ready, x_out, out_valid
   );

   // The reconstructor itself.
   modport slave (
      input  in_valid, s_in, d_in, out_ready,
      output in_ready, x_out, out_valid
   );
endinterface

// File: rtl/block_reconstructor.sv
// Inverse LeGall 5/3 lifting for one row: (s,d) pairs in, LENGTH clamped 8-bit pixels out, then done.
// Latency: first pixel is presented the cycle after pair 1 is accepted; done one cycle after the last pixel.
// Backpressure: input and output phases never overlap; out_valid/x_out hold while out_ready is low.
module block_reconstructor #(
   parameter int LENGTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   block_reconstructor_if.slave  bus,
   output logic                  busy,
   output logic                  done
);

   localparam int PAIRS = LENGTH / 2;
   localparam int CW    = $clog2(PAIRS + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACCEPT  = 3'd1,
      EMIT_E  = 3'd2,
      EMIT_O  = 3'd3,
      FLUSH_E = 3'd4,
      FLUSH_O = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t            state;
   logic [CW-1:0]     pair_cnt;

   // Two-deep history of even samples and details. After accepting pair n:
   // x_cur = x[2n], x_prev = x[2n-2], d_cur = d[n], d_prev = d[n-1].
   // Even samples stay unclamped so the odd prediction sees the true value.
   logic signed [10:0] x_prev;
   logic signed [10:0] x_cur;
   logic signed [10:0] d_prev;
   logic signed [10:0] d_cur;

   logic [7:0]        x_out_r;
   logic              in_ready_r;
   logic              out_valid_r;

   logic signed [10:0] s_ext;
   logic signed [10:0] d_ext;
   logic signed [10:0] d_left;
   logic signed [10:0] x_even_new;
   logic signed [10:0] x_odd;
   logic signed [10:0] x_last;

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.x_out     = x_out_r;

   function automatic logic [7:0] clamp8(input logic signed [10:0] v);
      if (v < 11'sd0)
         return 8'd0;
      else if (v > 11'sd255)
         return 8'hFF;
      else
         return v[7:0];
   endfunction

   // Lifting arithmetic: new even sample from the incoming pair, odd sample from two stored evens,
   // and the right-edge odd sample where the mirrored neighbour equals x[LENGTH-2].
   always_comb begin
      s_ext      = {3'b000, bus.s_in};
      d_ext      = {{3{bus.d_in[7]}}, bus.d_in};
      d_left     = (pair_cnt == '0) ? d_ext : d_cur;
      x_even_new = s_ext - ((d_left + d_ext + 11'sd2) >>> 2);
      x_odd      = d_prev + ((x_prev + x_cur) >>> 1);
      x_last     = d_cur + x_cur;
   end

   // Row sequencer with registered handshake outputs and sample pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pair_cnt    <= '0;
         x_prev      <= '0;
         x_cur       <= '0;
         d_prev      <= '0;
         d_cur       <= '0;
         x_out_r     <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= ACCEPT;
                  busy       <= 1'b1;
                  pair_cnt   <= '0;
                  in_ready_r <= 1'b1;
               end
            end

            ACCEPT: begin
               if (bus.in_valid && in_ready_r) begin
                  d_prev   <= d_cur;
                  d_cur    <= d_ext;
                  x_prev   <= x_cur;
                  x_cur    <= x_even_new;
                  pair_cnt <= pair_cnt + CW'(1);
                  // From pair 1 on, x[2n-2] (still in x_cur) and x[2n-1] are now computable.
                  if (pair_cnt != '0) begin
                     state       <= EMIT_E;
                     in_ready_r  <= 1'b0;
                     out_valid_r <= 1'b1;
                     x_out_r     <= clamp8(x_cur);
                  end
               end
            end

            EMIT_E: begin
               if (bus.out_ready) begin
                  state   <= EMIT_O;
                  x_out_r <= clamp8(x_odd);
               end
            end

            EMIT_O: begin
               if (bus.out_ready) begin
                  if (pair_cnt == CW'(PAIRS)) begin
                     state   <= FLUSH_E;
                     x_out_r <= clamp8(x_cur);
                  end else begin
                     state       <= ACCEPT;
                     out_valid_r <= 1'b0;
                     x_out_r     <= '0;
                     in_ready_r  <= 1'b1;
                  end
               end
            end

            FLUSH_E: begin
               if (bus.out_ready) begin
                  state   <= FLUSH_O;
                  x_out_r <= clamp8(x_last);
               end
            end

            FLUSH_O: begin
               if (bus.out_ready) begin
                  state       <= DONE;
                  out_valid_r <= 1'b0;
                  x_out_r     <= '0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_block_reconstructor.sv
// Randomised scoreboard bench for block_reconstructor against a floor-division reference model.
// Latency: checks first-sample and done timing on unstalled rows.
// Backpressure: out_ready held, toggled, randomised or held low; stall stability checked.
module tb_block_reconstructor;
   localparam int LENGTH = 8;
   localparam int PAIRS  = LENGTH / 2;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy;
   logic done;

   block_reconstructor_if bus();

   block_reconstructor #(.LENGTH(LENGTH)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ready_mode = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_hs_cyc = 0;
   int row_hs = 0;
   int stall_pend = 0;
   int stall_val = 0;
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int floor_div(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   function automatic int clamp(input int v);
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   // Whole-row reference: evens from the update step, then odds from the predict step with the mirror.
   task automatic model_row(input int s[PAIRS], input int d[PAIRS]);
      int xe[PAIRS+1];
      for (int n = 0; n < PAIRS; n++) begin
         int dl;
         dl = (n == 0) ? d[0] : d[n-1];
         xe[n] = s[n] - floor_div(dl + d[n] + 2, 4);
      end
      xe[PAIRS] = xe[PAIRS-1];
      for (int n = 0; n < PAIRS; n++) begin
         exp_q.push_back(8'(clamp(xe[n])));
         exp_q.push_back(8'(clamp(d[n] + floor_div(xe[n] + xe[n+1], 2))));
      end
   endtask

   // Downstream ready pattern.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: bus.out_ready = 1'b1;
         1: bus.out_ready = ~bus.out_ready;
         2: bus.out_ready = 1'($urandom_range(0, 1));
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on each output handshake, checks stalls, overlap and done timing.
   always @(negedge clk) begin
      if (reset) begin
         stall_pend = 0;
         row_hs = 0;
      end else begin
         if (stall_pend != 0) begin
            check("stall_valid_hold", int'(bus.out_valid), 1);
            check("stall_data_hold", int'(bus.x_out), stall_val);
            stall_pend = 0;
         end
         if (bus.out_valid) begin
            check("no_in_out_overlap", int'(bus.in_ready), 0);
            if (bus.out_ready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_sample: got %0d, expected no sample", bus.x_out);
               end else begin
                  check("sample", int'(bus.x_out), int'(exp_q.pop_front()));
               end
               last_hs_cyc = cyc + 1;
               row_hs++;
            end else begin
               stall_pend = 1;
               stall_val = int'(bus.x_out);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_after_last_hs", cyc, last_hs_cyc);
            check("hs_per_row", row_hs, LENGTH);
            check("busy_low_with_done", int'(busy), 0);
            row_hs = 0;
         end
      end
   end

   task automatic send_pair(input int s, input int d, input bit gap, output bit ok);
      ok = 1'b0;
      if (gap) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.s_in = 8'(s);
      bus.d_in = 8'(d);
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end else begin
         tests++;
         fails++;
         $display("FAIL in_ready_timeout: in_ready=%0d, required 1", bus.in_ready);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_row(input int s[PAIRS], input int d[PAIRS], input int mode,
                          input bit gaps, input bit dup_start, input bit timed);
      int dc0;
      int start_cyc;
      int t;
      bit ok;
      model_row(s, d);
      ready_mode = mode;
      dc0 = done_cnt;
      pulse_start();
      start_cyc = cyc;
      check("busy_after_start", int'(busy), 1);
      for (int p = 0; p < PAIRS; p++) begin
         if (dup_start && p == 2) start = 1'b1;
         send_pair(s[p], d[p], gaps, ok);
         start = 1'b0;
         if (dup_start && p == 2) check("busy_through_dup_start", int'(busy), 1);
      end
      bus.in_valid = 1'b0;
      t = 0;
      while (done_cnt == dc0 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      check("row_done_seen", done_cnt - dc0, 1);
      if (timed) check("row_cycles", done_cyc - start_cyc, PAIRS + LENGTH);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      check("busy_low_after_row", int'(busy), 0);
      check("out_valid_low_after_row", int'(bus.out_valid), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  int'(bus.in_ready), 0);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_x_out"},     int'(bus.x_out), 0);
      check({tag, "_busy"},      int'(busy), 0);
      check({tag, "_done"},      int'(done), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
      $fatal(1, "timeout");
   end

   initial begin
      int s[PAIRS];
      int d[PAIRS];
      bit ok;

      reset = 1'b1;
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.s_in = '0;
      bus.d_in = '0;
      bus.out_ready = 1'b0;
      #12;
      check_all_zero("reset");
      #10 reset = 1'b0;

      // Flat row with timing check.
      s = '{100, 100, 100, 100};
      d = '{0, 0, 0, 0};
      run_row(s, d, 0, 1'b0, 1'b0, 1'b1);

      // Ramp round trip.
      s = '{0, 4, 8, 13};
      d = '{0, 0, 0, 2};
      run_row(s, d, 0, 1'b0, 1'b0, 1'b1);

      // Clamp high and low.
      s = '{255, 255, 255, 255};
      d = '{127, 127, 127, 127};
      run_row(s, d, 0, 1'b0, 1'b0, 1'b1);
      s = '{0, 0, 0, 0};
      d = '{-128, -128, -128, -128};
      run_row(s, d, 0, 1'b0, 1'b0, 1'b1);

      // Ramp under alternating backpressure.
      s = '{0, 4, 8, 13};
      d = '{0, 0, 0, 2};
      run_row(s, d, 1, 1'b0, 1'b0, 1'b0);

      // in_valid while idle must not be taken.
      @(posedge clk);
      #1 bus.in_valid = 1'b1;
      bus.s_in = 8'd77;
      bus.d_in = 8'd5;
      repeat (3) begin
         @(negedge clk);
         check("idle_in_ready", int'(bus.in_ready), 0);
         check("idle_busy", int'(busy), 0);
      end
      bus.in_valid = 1'b0;
      run_row(s, d, 0, 1'b0, 1'b0, 1'b1);

      // Second start mid-row is ignored.
      for (int i = 0; i < PAIRS; i++) begin
         s[i] = int'($urandom_range(0, 255));
         d[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_row(s, d, 2, 1'b1, 1'b1, 1'b0);

      // Reset after two pairs abandons the row.
      ready_mode = 3;
      pulse_start();
      send_pair(50, 3, 1'b0, ok);
      send_pair(60, -7, 1'b0, ok);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1 check_all_zero("midrow_reset");
      @(posedge clk);
      #2 reset = 1'b0;
      ready_mode = 0;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_out_valid", int'(bus.out_valid), 0);
         check("post_reset_busy", int'(busy), 0);
      end
      s = '{0, 4, 8, 13};
      d = '{0, 0, 0, 2};
      run_row(s, d, 0, 1'b0, 1'b0, 1'b1);

      // Random rows with input gaps and random backpressure.
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < PAIRS; i++) begin
            s[i] = int'($urandom_range(0, 255));
            d[i] = int'($urandom_range(0, 255)) - 128;
         end
         run_row(s, d, 2, 1'b1, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
